// File: rtl/multicycle_controller_pkg.sv
// rtl/multicycle_controller_pkg.sv - shared encodings for the multicycle controller, ALU and datapath
// Holds FSM states, ALUOp/AluControl codes, opcodes and mux-select values.
package multicycle_controller_pkg;

   typedef enum logic [3:0] {
      S_FETCH,
      S_DECODE,
      S_MEMADR,
      S_MEMREAD,
      S_MEMWB,
      S_MEMWRITE,
      S_EXECUTER,
      S_EXECUTEI,
      S_ALUWB,
      S_BEQ,
      S_JAL
   } state_t;

   typedef enum logic [1:0] {
      ALUOP_ADD   = 2'b00,
      ALUOP_SUB   = 2'b01,
      ALUOP_FUNCT = 2'b10
   } alu_op_t;

   localparam logic [2:0] ALU_ADD = 3'b000;
   localparam logic [2:0] ALU_SUB = 3'b001;
   localparam logic [2:0] ALU_AND = 3'b010;
   localparam logic [2:0] ALU_OR  = 3'b011;
   localparam logic [2:0] ALU_SLT = 3'b101;

   localparam logic [6:0] OP_LW    = 7'b0000011;
   localparam logic [6:0] OP_SW    = 7'b0100011;
   localparam logic [6:0] OP_RTYPE = 7'b0110011;
   localparam logic [6:0] OP_ITYPE = 7'b0010011;
   localparam logic [6:0] OP_BEQ   = 7'b1100011;
   localparam logic [6:0] OP_JAL   = 7'b1101111;

   localparam logic       ADR_PC     = 1'b0;
   localparam logic       ADR_ALUOUT = 1'b1;

   localparam logic [1:0] SRCA_PC    = 2'b00;
   localparam logic [1:0] SRCA_OLDPC = 2'b01;
   localparam logic [1:0] SRCA_RD1   = 2'b10;

   localparam logic [1:0] SRCB_RD2   = 2'b00;
   localparam logic [1:0] SRCB_IMM   = 2'b01;
   localparam logic [1:0] SRCB_FOUR  = 2'b10;

   localparam logic [1:0] RES_ALUOUT    = 2'b00;
   localparam logic [1:0] RES_DATA      = 2'b01;
   localparam logic [1:0] RES_ALURESULT = 2'b10;

   localparam logic [1:0] IMM_I = 2'b00;
   localparam logic [1:0] IMM_S = 2'b01;
   localparam logic [1:0] IMM_B = 2'b10;
   localparam logic [1:0] IMM_J = 2'b11;

   // Immediate format depends only on the opcode, independent of FSM state.
   function automatic logic [1:0] imm_src_for(input logic [6:0] op);
      logic [1:0] imm;
      case (op)
         OP_SW:   imm = IMM_S;
         OP_BEQ:  imm = IMM_B;
         OP_JAL:  imm = IMM_J;
         default: imm = IMM_I;
      endcase
      return imm;
   endfunction

endpackage

// File: rtl/alu_decoder.sv
// rtl/alu_decoder.sv - combinational ALUOp/funct to AluControl mapping
module alu_decoder
   import multicycle_controller_pkg::*;
(
   input  alu_op_t    alu_op_i,
   input  logic [2:0] funct3_i,
   input  logic       op_b5_i,
   input  logic       funct7b5_i,
   output logic [2:0] alu_control_o
);

   always_comb begin
      alu_control_o = ALU_ADD;
      case (alu_op_i)
         ALUOP_ADD: alu_control_o = ALU_ADD;
         ALUOP_SUB: alu_control_o = ALU_SUB;
         ALUOP_FUNCT: begin
            case (funct3_i)
               // funct7b5 only means SUB for register-register ops; addi may carry it in its immediate
               3'b000:  alu_control_o = (op_b5_i & funct7b5_i) ? ALU_SUB : ALU_ADD;
               3'b010:  alu_control_o = ALU_SLT;
               3'b110:  alu_control_o = ALU_OR;
               3'b111:  alu_control_o = ALU_AND;
               default: alu_control_o = ALU_ADD;
            endcase
         end
         default: alu_control_o = ALU_ADD;
      endcase
   end

endmodule

// File: rtl/multicycle_controller.sv
// rtl/multicycle_controller.sv - Moore FSM control unit for a multicycle RISC-V datapath
module multicycle_controller
   import multicycle_controller_pkg::*;
(
   input  logic       clk,
   input  logic       rst_n,
   input  logic [6:0] op,
   input  logic [2:0] funct3,
   input  logic       funct7b5,
   input  logic       Zero,
   output logic       PCWrite,
   output logic       IRWrite,
   output logic       MemWrite,
   output logic       RegWrite,
   output logic       AdrSrc,
   output logic [1:0] ALUSrcA,
   output logic [1:0] ALUSrcB,
   output logic [1:0] ResultSrc,
   output logic [1:0] ImmSrc,
   output logic [2:0] AluControl
);

   state_t  state_q, state_d;
   alu_op_t alu_op;
   logic    pc_update;
   logic    branch;
   logic    ir_write;
   logic    mem_write;
   logic    reg_write;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state_q <= S_FETCH;
      else        state_q <= state_d;
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         S_FETCH: state_d = S_DECODE;
         S_DECODE: begin
            case (op)
               OP_LW, OP_SW: state_d = S_MEMADR;
               OP_RTYPE:     state_d = S_EXECUTER;
               OP_ITYPE:     state_d = S_EXECUTEI;
               OP_BEQ:       state_d = S_BEQ;
               OP_JAL:       state_d = S_JAL;
               default:      state_d = S_FETCH;
            endcase
         end
         S_MEMADR: begin
            if (op == OP_LW)      state_d = S_MEMREAD;
            else if (op == OP_SW) state_d = S_MEMWRITE;
            else                  state_d = S_FETCH;
         end
         S_MEMREAD:                        state_d = S_MEMWB;
         S_EXECUTER, S_EXECUTEI, S_JAL:    state_d = S_ALUWB;
         S_MEMWB, S_MEMWRITE, S_ALUWB,
         S_BEQ:                            state_d = S_FETCH;
         default:                          state_d = S_FETCH;
      endcase
   end

   always_comb begin
      pc_update = 1'b0;
      branch    = 1'b0;
      ir_write  = 1'b0;
      mem_write = 1'b0;
      reg_write = 1'b0;
      AdrSrc    = ADR_PC;
      ALUSrcA   = SRCA_PC;
      ALUSrcB   = SRCB_RD2;
      ResultSrc = RES_ALUOUT;
      alu_op    = ALUOP_ADD;
      case (state_q)
         S_FETCH: begin
            ir_write  = 1'b1;
            pc_update = 1'b1;
            AdrSrc    = ADR_PC;
            ALUSrcA   = SRCA_PC;
            ALUSrcB   = SRCB_FOUR;
            ResultSrc = RES_ALURESULT;
         end
         S_DECODE: begin
            ALUSrcA = SRCA_OLDPC;
            ALUSrcB = SRCB_IMM;
         end
         S_MEMADR: begin
            ALUSrcA = SRCA_RD1;
            ALUSrcB = SRCB_IMM;
         end
         S_MEMREAD: AdrSrc = ADR_ALUOUT;
         S_MEMWB: begin
            ResultSrc = RES_DATA;
            reg_write = 1'b1;
         end
         S_MEMWRITE: begin
            AdrSrc    = ADR_ALUOUT;
            mem_write = 1'b1;
         end
         S_EXECUTER: begin
            ALUSrcA = SRCA_RD1;
            ALUSrcB = SRCB_RD2;
            alu_op  = ALUOP_FUNCT;
         end
         S_EXECUTEI: begin
            ALUSrcA = SRCA_RD1;
            ALUSrcB = SRCB_IMM;
            alu_op  = ALUOP_FUNCT;
         end
         S_ALUWB: reg_write = 1'b1;
         S_BEQ: begin
            ALUSrcA = SRCA_RD1;
            ALUSrcB = SRCB_RD2;
            alu_op  = ALUOP_SUB;
            branch  = 1'b1;
         end
         S_JAL: begin
            ALUSrcA   = SRCA_OLDPC;
            ALUSrcB   = SRCB_FOUR;
            pc_update = 1'b1;
         end
         default: ;
      endcase
   end

   // Reset gates the enables directly so they drop without waiting for a clock edge.
   assign PCWrite  = rst_n & (pc_update | (branch & Zero));
   assign IRWrite  = rst_n & ir_write;
   assign MemWrite = rst_n & mem_write;
   assign RegWrite = rst_n & reg_write;
   assign ImmSrc   = imm_src_for(op);

   alu_decoder u_alu_decoder (
      .alu_op_i      (alu_op),
      .funct3_i      (funct3),
      .op_b5_i       (op[5]),
      .funct7b5_i    (funct7b5),
      .alu_control_o (AluControl)
   );

endmodule

// File: tb/tb_multicycle_controller.sv
// tb/tb_multicycle_controller.sv - scoreboard bench for multicycle_controller
module tb_multicycle_controller;

   localparam int T_FETCH = 0, T_DECODE = 1, T_MEMADR = 2, T_MEMREAD = 3, T_MEMWB = 4,
                  T_MEMWRITE = 5, T_EXECR = 6, T_EXECI = 7, T_ALUWB = 8, T_BEQ = 9,
                  T_JAL = 10, T_RST = 11;

   logic       clk, rst_n;
   logic [6:0] op;
   logic [2:0] funct3;
   logic       funct7b5, Zero;
   logic       PCWrite, IRWrite, MemWrite, RegWrite, AdrSrc;
   logic [1:0] ALUSrcA, ALUSrcB, ResultSrc, ImmSrc;
   logic [2:0] AluControl;

   string       name_q[$];
   logic [15:0] vec_q[$];
   int          n_checks = 0;
   int          n_fail   = 0;
   event        chk_ev;

   multicycle_controller dut (
      .clk(clk), .rst_n(rst_n), .op(op), .funct3(funct3), .funct7b5(funct7b5), .Zero(Zero),
      .PCWrite(PCWrite), .IRWrite(IRWrite), .MemWrite(MemWrite), .RegWrite(RegWrite),
      .AdrSrc(AdrSrc), .ALUSrcA(ALUSrcA), .ALUSrcB(ALUSrcB), .ResultSrc(ResultSrc),
      .ImmSrc(ImmSrc), .AluControl(AluControl)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   // {PCWrite, IRWrite, MemWrite, RegWrite, AdrSrc, ALUSrcA, ALUSrcB, ResultSrc}
   function automatic logic [10:0] base(input int st, input logic z);
      logic [10:0] b;
      case (st)
         T_FETCH:    b = {4'b1100, 1'b0, 2'b00, 2'b10, 2'b10};
         T_DECODE:   b = {4'b0000, 1'b0, 2'b01, 2'b01, 2'b00};
         T_MEMADR:   b = {4'b0000, 1'b0, 2'b10, 2'b01, 2'b00};
         T_MEMREAD:  b = {4'b0000, 1'b1, 2'b00, 2'b00, 2'b00};
         T_MEMWB:    b = {4'b0001, 1'b0, 2'b00, 2'b00, 2'b01};
         T_MEMWRITE: b = {4'b0010, 1'b1, 2'b00, 2'b00, 2'b00};
         T_EXECR:    b = {4'b0000, 1'b0, 2'b10, 2'b00, 2'b00};
         T_EXECI:    b = {4'b0000, 1'b0, 2'b10, 2'b01, 2'b00};
         T_ALUWB:    b = {4'b0001, 1'b0, 2'b00, 2'b00, 2'b00};
         T_BEQ:      b = {z, 3'b000, 1'b0, 2'b10, 2'b00, 2'b00};
         T_JAL:      b = {4'b1000, 1'b0, 2'b01, 2'b10, 2'b00};
         default:    b = {4'b0000, 1'b0, 2'b00, 2'b10, 2'b10};
      endcase
      return b;
   endfunction

   task automatic push(input string nm, input logic [15:0] v);
      name_q.push_back(nm);
      vec_q.push_back(v);
   endtask

   task automatic step(input string nm, input int st, input logic z, input logic [1:0] imm,
                       input logic [2:0] alu);
      push($sformatf("%s/st%0d", nm, st), {base(st, z), imm, alu});
      @(posedge clk);
      #1;
   endtask

   task automatic instr(input string nm, input logic [6:0] o, input logic [2:0] f3,
                        input logic f7, input logic z, input logic [1:0] imm,
                        input logic [2:0] exe_alu, input int nsteps);
      int seq[$];
      logic [2:0] a;
      op = o; funct3 = f3; funct7b5 = f7; Zero = z;
      seq.push_back(T_FETCH);
      seq.push_back(T_DECODE);
      case (o)
         7'b0000011: begin seq.push_back(T_MEMADR); seq.push_back(T_MEMREAD); seq.push_back(T_MEMWB); end
         7'b0100011: begin seq.push_back(T_MEMADR); seq.push_back(T_MEMWRITE); end
         7'b0110011: begin seq.push_back(T_EXECR); seq.push_back(T_ALUWB); end
         7'b0010011: begin seq.push_back(T_EXECI); seq.push_back(T_ALUWB); end
         7'b1100011: seq.push_back(T_BEQ);
         7'b1101111: begin seq.push_back(T_JAL); seq.push_back(T_ALUWB); end
         default: ;
      endcase
      for (int i = 0; i < seq.size() && i < nsteps; i++) begin
         if (seq[i] == T_EXECR || seq[i] == T_EXECI) a = exe_alu;
         else if (seq[i] == T_BEQ)                   a = 3'b001;
         else                                        a = 3'b000;
         step(nm, seq[i], z, imm, a);
      end
   endtask

   initial begin : monitor
      string       nm;
      logic [15:0] e, act;
      forever begin
         @(negedge clk or chk_ev);
         if (vec_q.size() > 0) begin
            nm  = name_q.pop_front();
            e   = vec_q.pop_front();
            act = {PCWrite, IRWrite, MemWrite, RegWrite, AdrSrc, ALUSrcA, ALUSrcB,
                   ResultSrc, ImmSrc, AluControl};
            n_checks++;
            if (act !== e) begin
               n_fail++;
               $display("FAIL %s: got %h, expected %h", nm, act, e);
            end
         end
      end
   end

   initial begin : watchdog
      #100000;
      $display("FAIL watchdog: bench timed out, got no end, expected end of test");
      $fatal(1, "timeout");
   end

   initial begin : stim
      rst_n = 1'b0; op = 7'b0; funct3 = 3'b0; funct7b5 = 1'b0; Zero = 1'b0;
      #2;
      push("reset_async", {base(T_RST, 1'b0), 2'b00, 3'b000});
      #1 -> chk_ev;
      @(posedge clk); #1;
      push("reset_hold", {base(T_RST, 1'b0), 2'b00, 3'b000});
      @(posedge clk); #1;
      rst_n = 1'b1;

      instr("lw",      7'b0000011, 3'b010, 1'b0, 1'b0, 2'b00, 3'b000, 99);
      instr("sw",      7'b0100011, 3'b010, 1'b0, 1'b0, 2'b01, 3'b000, 99);
      instr("sub",     7'b0110011, 3'b000, 1'b1, 1'b0, 2'b00, 3'b001, 99);
      instr("addi_f7", 7'b0010011, 3'b000, 1'b1, 1'b0, 2'b00, 3'b000, 99);
      instr("add_z1",  7'b0110011, 3'b000, 1'b0, 1'b1, 2'b00, 3'b000, 99);
      instr("slti",    7'b0010011, 3'b010, 1'b0, 1'b0, 2'b00, 3'b101, 99);
      instr("ori",     7'b0010011, 3'b110, 1'b0, 1'b0, 2'b00, 3'b011, 99);
      instr("andi",    7'b0010011, 3'b111, 1'b0, 1'b0, 2'b00, 3'b010, 99);
      instr("xori",    7'b0010011, 3'b100, 1'b0, 1'b0, 2'b00, 3'b000, 99);
      instr("and_r",   7'b0110011, 3'b111, 1'b0, 1'b0, 2'b00, 3'b010, 99);
      instr("beq_z1",  7'b1100011, 3'b000, 1'b0, 1'b1, 2'b10, 3'b000, 99);
      instr("beq_z0",  7'b1100011, 3'b000, 1'b0, 1'b0, 2'b10, 3'b000, 99);
      instr("jal",     7'b1101111, 3'b000, 1'b0, 1'b0, 2'b11, 3'b000, 99);
      instr("unsup0",  7'b0000000, 3'b000, 1'b0, 1'b1, 2'b00, 3'b000, 99);
      instr("unsup73", 7'b1110011, 3'b000, 1'b0, 1'b0, 2'b00, 3'b000, 99);

      instr("sw_rst",  7'b0100011, 3'b010, 1'b0, 1'b0, 2'b01, 3'b000, 3);
      push("sw_rst/memwrite", {base(T_MEMWRITE, 1'b0), 2'b01, 3'b000});
      @(negedge clk); #1;
      rst_n = 1'b0;
      push("reset_mid_memwrite", {base(T_RST, 1'b0), 2'b01, 3'b000});
      #1 -> chk_ev;
      @(posedge clk); #1;
      push("reset_mid_hold", {base(T_RST, 1'b0), 2'b01, 3'b000});
      @(posedge clk); #1;
      rst_n = 1'b1;
      instr("jal_after_rst", 7'b1101111, 3'b000, 1'b0, 1'b0, 2'b11, 3'b000, 99);
      instr("lw_final",      7'b0000011, 3'b010, 1'b0, 1'b0, 2'b00, 3'b000, 99);

      @(negedge clk); #1;
      n_checks++;
      if (vec_q.size() != 0) begin
         n_fail++;
         $display("FAIL scoreboard_drain: got %0d pending, expected 0", vec_q.size());
      end
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule

// File: doc/multicycle_controller.md
MULTICYCLE_CONTROLLER -- requirements
Module: multicycle_controller

Interface
REQ-001 SHALL have one clock and an asynchronous, active-low reset: clk input 1 (rising edge); rst_n input 1 (async assert, active low).
REQ-002 SHALL have these decode inputs: op input 7 (instr[6:0]); funct3 input 3 (instr[14:12]); funct7b5 input 1 (instr[30]); Zero input 1 (ALU zero flag).
REQ-003 SHALL have these write-enable outputs: PCWrite output 1; IRWrite output 1; MemWrite output 1; RegWrite output 1.
REQ-004 SHALL have these mux-select outputs: AdrSrc output 1 (0=PC, 1=ALUOut); ALUSrcA output 2 (00=PC, 01=OldPC, 10=RD1); ALUSrcB output 2 (00=RD2, 01=ImmExt, 10=constant 4); ResultSrc output 2 (00=ALUOut, 01=Data, 10=ALUResult); ImmSrc output 2 (00=I, 01=S, 10=B, 11=J).
REQ-005 SHALL drive AluControl output 3 using the ALU encoding: 000 ADD, 001 SUB, 010 AND, 011 OR, 101 SLT.

Function
REQ-006 SHALL implement a Moore FSM with states FETCH, DECODE, MEMADR, MEMREAD, MEMWB, MEMWRITE, EXECUTER, EXECUTEI, ALUWB, BEQ, JAL.
REQ-007 SHALL apply these state outputs (ALUOp 00=add, 01=sub, 10=funct; unlisted outputs 0):
- FETCH: IRWrite=1, AdrSrc=0, ALUSrcA=00, ALUSrcB=10, ALUOp=00, ResultSrc=10, PCUpdate=1.
- DECODE: ALUSrcA=01, ALUSrcB=01, ALUOp=00.
- MEMADR: ALUSrcA=10, ALUSrcB=01, ALUOp=00.
- MEMREAD: ResultSrc=00, AdrSrc=1.
- MEMWB: ResultSrc=01, RegWrite=1.
- MEMWRITE: ResultSrc=00, AdrSrc=1, MemWrite=1.
- EXECUTER: ALUSrcA=10, ALUSrcB=00, ALUOp=10.
- EXECUTEI: ALUSrcA=10, ALUSrcB=01, ALUOp=10.
- ALUWB: ResultSrc=00, RegWrite=1.
- BEQ: ALUSrcA=10, ALUSrcB=00, ALUOp=01, ResultSrc=00, Branch=1.
- JAL: ALUSrcA=01, ALUSrcB=10, ALUOp=00, ResultSrc=00, PCUpdate=1.
REQ-008 SHALL use these transitions:
- FETCH->DECODE.
- DECODE by op: 0000011/0100011->MEMADR; 0110011->EXECUTER; 0010011->EXECUTEI; 1100011->BEQ; 1101111->JAL; any other op->FETCH.
- MEMADR: lw->MEMREAD, sw->MEMWRITE.
- MEMREAD->MEMWB.
- EXECUTER/EXECUTEI/JAL->ALUWB.
- MEMWB/MEMWRITE/ALUWB/BEQ->FETCH.
REQ-009 SHALL compute PCWrite = PCUpdate | (Branch & Zero) combinationally; Zero is sampled only in BEQ.
REQ-010 SHALL decode ImmSrc combinationally from op in every state: lw/I-ALU 00, sw 01, beq 10, jal 11, others 00.
REQ-011 SHALL derive AluControl from ALUOp:
- ALUOp 00 -> 000; ALUOp 01 -> 001.
- ALUOp 10, funct3 000 -> 001 if (op[5] & funct7b5), else 000.
- ALUOp 10, funct3 010 -> 101; 110 -> 011; 111 -> 010; other funct3 -> 000.
REQ-012 SHALL give these instruction latencies, counted FETCH to the next FETCH: lw 5, sw 4, R-type 4, I-ALU 4, jal 4, beq 3, unsupported op 2 (no write enable asserted outside FETCH).
REQ-013 SHALL produce outputs that are a function of the current state and the op/funct inputs only, with no extra pipeline register.

Reset
REQ-014 SHALL force the state to FETCH asynchronously while rst_n=0, including mid-instruction.
REQ-015 SHALL hold PCWrite, IRWrite, MemWrite and RegWrite at 0 while rst_n=0; other outputs take their FETCH values.
REQ-016 SHALL perform its first FETCH (IRWrite=1, PCWrite=1) on the first rising clk edge after rst_n deasserts.

Structure
REQ-017 SHALL place the state enum, ALUOp codes, AluControl codes, opcode constants and mux-select encodings in a shared package, which the ALU and datapath also import.
REQ-018 SHALL implement the ALUOp/funct-to-AluControl mapping as one combinational sub-module, alu_decoder; the FSM and output logic live in multicycle_controller.

Verification
REQ-019 SHALL pass lw: op=0000011 -> states FETCH, DECODE, MEMADR, MEMREAD, MEMWB; RegWrite=1 and ResultSrc=01 only in cycle 5; then FETCH.
REQ-020 SHALL pass R-type SUB: op=0110011, funct3=000, funct7b5=1 -> AluControl=001 in EXECUTER; the same inputs with op=0010011 -> AluControl=000 (addi).
REQ-021 SHALL pass beq: op=1100011 with Zero=1 in BEQ -> PCWrite=1; with Zero=0 -> PCWrite=0; both cases return to FETCH after 3 cycles.
REQ-022 SHALL pass an unsupported op (0000000): DECODE->FETCH; MemWrite, RegWrite and PCWrite stay 0 in DECODE.
REQ-023 SHALL pass reset mid-instruction: rst_n=0 during MEMWRITE -> MemWrite drops to 0 immediately (asynchronously); after release, the state is FETCH.
REQ-024 SHALL pass SLT/OR/AND: funct3 010/110/111 in EXECUTEI -> AluControl 101/011/010.
